// File: rtl/lfp_q6_11_pkg.sv
// Shared Q6.11 fixed-point types and constants for the LSTM datapath stages.
// Also holds the state encoding of the dot-product engine.
package lfp_q6_11_pkg;

    localparam int Q_W    = 18;
    localparam int Q_FRAC = 11;

    typedef logic signed [Q_W-1:0] q6_11_t;

    localparam q6_11_t Q_MAX = 18'sd131071;
    localparam q6_11_t Q_MIN = -18'sd131072;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        OUT
    } state_t;

endpackage

// File: rtl/lfp_dot_acc_q6_11_if.sv
// Start/beat/result handshake bundle of the Q6.11 dot-product engine.
interface lfp_dot_acc_q6_11_if
    import lfp_q6_11_pkg::*;
#(
    parameter int DW = Q_W
);

    logic                 start;
    logic signed [DW-1:0] bias_q;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x_q;
    logic signed [DW-1:0] w_q;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_q;
    logic                 out_sat;
    logic                 busy;

    modport slave (
        input  start, bias_q, in_valid, x_q, w_q, out_ready,
        output in_ready, out_valid, out_q, out_sat, busy
    );

    modport master (
        output start, bias_q, in_valid, x_q, w_q, out_ready,
        input  in_ready, out_valid, out_q, out_sat, busy
    );

endinterface

// File: rtl/lfp_round_sat_q6_11.sv
// Rounds a wide accumulator (FRAC extra fraction bits) half toward +inf
// and saturates it into a DW-bit signed result.
module lfp_round_sat_q6_11
    import lfp_q6_11_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int DW    = Q_W,
    parameter int FRAC  = Q_FRAC
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [DW-1:0]    q,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) << (DW - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] rounded;

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        rounded = (acc + HALF) >>> FRAC;
        q       = rounded[DW-1:0];
        sat     = 1'b0;
        if (rounded > MAX_V) begin
            q   = MAX_V[DW-1:0];
            sat = 1'b1;
        end else if (rounded < MIN_V) begin
            q   = MIN_V[DW-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/lfp_dot_acc_q6_11.sv
// Sequential Q6.11 dot product: bias + sum(w*x) over VEC_LEN beats, then
// round/saturate to Q6.11 and hold it on a valid/ready output.
module lfp_dot_acc_q6_11
    import lfp_q6_11_pkg::*;
#(
    parameter int VEC_LEN = 16,
    parameter int DW      = Q_W,
    parameter int FRAC    = Q_FRAC,
    parameter int ACC_W   = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    lfp_dot_acc_q6_11_if.slave  bus
);

    localparam int                CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(VEC_LEN - 1);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [DW-1:0]    rs_q;
    logic                    rs_sat;
    logic signed [DW-1:0]    out_q_r;
    logic                    out_sat_r;
    logic                    beat;

    // Full-width product; nothing is dropped before accumulation.
    assign prod     = (2*DW)'(bus.x_q) * (2*DW)'(bus.w_q);
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(ACC_W-DW-FRAC){bus.bias_q[DW-1]}}, bus.bias_q, {FRAC{1'b0}}};
    assign beat     = (state == ACCUM) && bus.in_valid;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE:  if (bus.start) state_nxt = ACCUM;
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && cnt == LAST) state_nxt = FINAL;
            end
            FINAL: state_nxt = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_q_r   <= '0;
            out_sat_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    acc <= bias_ext;
                    cnt <= '0;
                end
                ACCUM: if (beat) begin
                    acc <= acc + prod_ext;
                    cnt <= cnt + 1'b1;
                end
                FINAL: begin
                    out_q_r   <= rs_q;
                    out_sat_r <= rs_sat;
                end
                default: ;
            endcase
        end
    end

    lfp_round_sat_q6_11 #(
        .ACC_W (ACC_W),
        .DW    (DW),
        .FRAC  (FRAC)
    ) u_round_sat (
        .acc (acc),
        .q   (rs_q),
        .sat (rs_sat)
    );

    assign bus.out_q   = out_q_r;
    assign bus.out_sat = out_sat_r;

endmodule
